mem_arbiter: RTL and testbench

Two-port arbiter sharing one data-memory port between the load/store path (port 0, behind the dcache interface) and the instruction-refill path (port 1). Requesters use the level-held request/valid handshake already used between the load/store unit and the dcache: a request stays asserted until its matching valid is seen. The arbiter grants one port at a time with round-robin fairness and holds the grant until the transaction completes. It steers the selected request to memory and routes the response back. A watchdog flags transactions that never complete.

---
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one data-memory port between the load/store path
// (port 0) and the instruction-refill path (port 1). Round-robin grant held
// for a full transaction, combinational request steering and response routing,
// and a sticky watchdog for transactions that never complete.
module mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    // port 0: load/store path
    input  logic [31:0] i_p0_addr,
    input  logic        i_p0_wreq,
    input  logic        i_p0_rreq,
    input  logic [31:0] i_p0_wdata,
    input  logic [3:0]  i_p0_byte_enable,
    output logic        o_p0_wvalid,
    output logic        o_p0_rvalid,
    output logic [31:0] o_p0_rdata,
    // port 1: instruction refill path
    input  logic [31:0] i_p1_addr,
    input  logic        i_p1_wreq,
    input  logic        i_p1_rreq,
    input  logic [31:0] i_p1_wdata,
    input  logic [3:0]  i_p1_byte_enable,
    output logic        o_p1_wvalid,
    output logic        o_p1_rvalid,
    output logic [31:0] o_p1_rdata,
    // shared memory port
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_mem_wreq,
    output logic        o_mem_rreq,
    output logic [3:0]  o_mem_byte_enable,
    input  logic        i_mem_wvalid,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    // status
    output logic        o_busy,
    output logic        o_grant,
    output logic        o_timeout
);

    // Counter is at least 8 bits and wide enough to hold TIMEOUT_CYCLES.
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CW:0] C_LIMIT = (CW + 1)'(TIMEOUT_CYCLES);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t        r_state;
    logic          r_grant;
    logic          r_last_grant;
    logic          r_timeout;
    logic [CW-1:0] r_cnt;

    logic          w_busy;
    logic          w_req0;
    logic          w_req1;
    logic          w_win;
    logic          w_sel_wreq;
    logic          w_sel_rreq;
    logic [31:0]   w_sel_addr;
    logic [31:0]   w_sel_wdata;
    logic [3:0]    w_sel_be;
    logic          w_done_w;
    logic          w_done_r;
    logic [CW:0]   w_cnt_inc;

    assign w_busy = (r_state == ST_BUSY);
    assign w_req0 = i_p0_wreq | i_p0_rreq;
    assign w_req1 = i_p1_wreq | i_p1_rreq;

    // On a tie the port that did not complete last wins; otherwise the lone requester.
    assign w_win = (w_req0 & w_req1) ? ~r_last_grant : w_req1;

    // Granted port's request fields.
    assign w_sel_wreq  = r_grant ? i_p1_wreq        : i_p0_wreq;
    assign w_sel_rreq  = r_grant ? i_p1_rreq        : i_p0_rreq;
    assign w_sel_addr  = r_grant ? i_p1_addr        : i_p0_addr;
    assign w_sel_wdata = r_grant ? i_p1_wdata       : i_p0_wdata;
    assign w_sel_be    = r_grant ? i_p1_byte_enable : i_p0_byte_enable;

    // Memory side is forced quiet in IDLE; a write masks a simultaneous read.
    assign o_mem_wreq        = w_busy & w_sel_wreq;
    assign o_mem_rreq        = w_busy & w_sel_rreq & ~w_sel_wreq;
    assign o_mem_addr        = w_busy ? w_sel_addr  : 32'd0;
    assign o_mem_wdata       = w_busy ? w_sel_wdata : 32'd0;
    assign o_mem_byte_enable = w_busy ? w_sel_be    : 4'd0;

    // Only a valid matching the forwarded request type completes the transaction.
    assign w_done_w = o_mem_wreq & i_mem_wvalid;
    assign w_done_r = o_mem_rreq & i_mem_rvalid;

    assign o_p0_wvalid = w_done_w & ~r_grant;
    assign o_p1_wvalid = w_done_w &  r_grant;
    assign o_p0_rvalid = w_done_r & ~r_grant;
    assign o_p1_rvalid = w_done_r &  r_grant;
    assign o_p0_rdata  = (w_busy & ~r_grant) ? i_mem_rdata : 32'd0;
    assign o_p1_rdata  = (w_busy &  r_grant) ? i_mem_rdata : 32'd0;

    assign o_busy    = w_busy;
    assign o_grant   = r_grant;
    assign o_timeout = r_timeout;

    assign w_cnt_inc = {1'b0, r_cnt} + {{CW{1'b0}}, 1'b1};

    // Grant FSM: arbitrate in IDLE, hold through BUSY until completion or abort,
    // counting stalled BUSY cycles for the watchdog.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_timeout    <= 1'b0;
            r_cnt        <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_req0 | w_req1) begin
                r_state <= ST_BUSY;
                r_grant <= w_win;
                r_cnt   <= '0;
            end
        end else begin
            if (w_done_w | w_done_r) begin
                r_state      <= ST_IDLE;
                r_last_grant <= r_grant;
            end else if (!(w_sel_wreq | w_sel_rreq)) begin
                // requester withdrew: drop the grant without touching fairness state
                r_state <= ST_IDLE;
            end else begin
                if (!(&r_cnt))
                    r_cnt <= w_cnt_inc[CW-1:0];
                if (w_cnt_inc >= C_LIMIT)
                    r_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_mem_arbiter;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata, mem_rdata;
    logic        p0_wreq, p0_rreq, p1_wreq, p1_rreq, mem_wvalid, mem_rvalid;
    logic [3:0]  p0_be, p1_be;

    logic        o_p0_wvalid, o_p0_rvalid, o_p1_wvalid, o_p1_rvalid;
    logic [31:0] o_p0_rdata, o_p1_rdata, o_mem_addr, o_mem_wdata;
    logic        o_mem_wreq, o_mem_rreq, o_busy, o_grant, o_timeout;
    logic [3:0]  o_mem_be;

    int n_chk = 0;
    int n_fail = 0;

    // model state: one outstanding transaction at most
    bit m_busy, m_grant, m_last, m_to;
    int m_cnt;
    bit n_busy, n_grant, n_last, n_to;
    int n_cnt;
    bit e_done0, e_done1;

    // random requester state
    bit       h0, h1;
    bit [1:0] k0, k1;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_p0_addr(p0_addr), .i_p0_wreq(p0_wreq), .i_p0_rreq(p0_rreq),
        .i_p0_wdata(p0_wdata), .i_p0_byte_enable(p0_be),
        .o_p0_wvalid(o_p0_wvalid), .o_p0_rvalid(o_p0_rvalid), .o_p0_rdata(o_p0_rdata),
        .i_p1_addr(p1_addr), .i_p1_wreq(p1_wreq), .i_p1_rreq(p1_rreq),
        .i_p1_wdata(p1_wdata), .i_p1_byte_enable(p1_be),
        .o_p1_wvalid(o_p1_wvalid), .o_p1_rvalid(o_p1_rvalid), .o_p1_rdata(o_p1_rdata),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_wreq(o_mem_wreq),
        .o_mem_rreq(o_mem_rreq), .o_mem_byte_enable(o_mem_be),
        .i_mem_wvalid(mem_wvalid), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
        .o_busy(o_busy), .o_grant(o_grant), .o_timeout(o_timeout)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_busy = 0; m_grant = 0; m_last = 1; m_to = 0; m_cnt = 0;
    endtask

    task automatic clr_in();
        p0_addr = 0; p0_wdata = 0; p0_wreq = 0; p0_rreq = 0; p0_be = 0;
        p1_addr = 0; p1_wdata = 0; p1_wreq = 0; p1_rreq = 0; p1_be = 0;
        mem_wvalid = 0; mem_rvalid = 0; mem_rdata = 0;
    endtask

    // Expected outputs for this cycle from the held transaction and current inputs,
    // then the transaction state for the next cycle.
    task automatic model_check();
        bit r0, r1, gw, gr, fw, fr, dw, dr;
        logic [31:0] ea, ewd, erd0, erd1;
        logic [3:0] ebe;
        r0 = p0_wreq | p0_rreq;
        r1 = p1_wreq | p1_rreq;
        gw = m_grant ? p1_wreq : p0_wreq;
        gr = m_grant ? p1_rreq : p0_rreq;
        fw = m_busy & gw;
        fr = m_busy & gr & ~gw;
        ea  = !m_busy ? 32'd0 : (m_grant ? p1_addr  : p0_addr);
        ewd = !m_busy ? 32'd0 : (m_grant ? p1_wdata : p0_wdata);
        ebe = !m_busy ? 4'd0  : (m_grant ? p1_be    : p0_be);
        dw = fw & mem_wvalid;
        dr = fr & mem_rvalid;
        erd0 = (m_busy && m_grant == 0) ? mem_rdata : 32'd0;
        erd1 = (m_busy && m_grant == 1) ? mem_rdata : 32'd0;
        chk("mem_wreq", {31'd0, o_mem_wreq}, {31'd0, fw});
        chk("mem_rreq", {31'd0, o_mem_rreq}, {31'd0, fr});
        chk("mem_addr", o_mem_addr, ea);
        chk("mem_wdata", o_mem_wdata, ewd);
        chk("mem_be", {28'd0, o_mem_be}, {28'd0, ebe});
        chk("p0_wvalid", {31'd0, o_p0_wvalid}, {31'd0, dw & ~m_grant});
        chk("p1_wvalid", {31'd0, o_p1_wvalid}, {31'd0, dw & m_grant});
        chk("p0_rvalid", {31'd0, o_p0_rvalid}, {31'd0, dr & ~m_grant});
        chk("p1_rvalid", {31'd0, o_p1_rvalid}, {31'd0, dr & m_grant});
        chk("p0_rdata", o_p0_rdata, erd0);
        chk("p1_rdata", o_p1_rdata, erd1);
        chk("busy", {31'd0, o_busy}, {31'd0, m_busy});
        chk("timeout", {31'd0, o_timeout}, {31'd0, m_to});
        if (m_busy) chk("grant", {31'd0, o_grant}, {31'd0, m_grant});
        e_done0 = (dw | dr) & ~m_grant;
        e_done1 = (dw | dr) & m_grant;
        n_busy = m_busy; n_grant = m_grant; n_last = m_last; n_to = m_to; n_cnt = m_cnt;
        if (!m_busy) begin
            if (r0 | r1) begin
                n_busy = 1;
                n_grant = (r0 & r1) ? ~m_last : r1;
                n_cnt = 0;
            end
        end else if (dw | dr) begin
            n_busy = 0;
            n_last = m_grant;
        end else if (!(gw | gr)) begin
            n_busy = 0;
        end else begin
            n_cnt = m_cnt + 1;
            if (n_cnt >= T) n_to = 1;
        end
    endtask

    task automatic half();
        @(negedge clk);
        model_check();
    endtask

    task automatic adv();
        @(posedge clk);
        if (!rst_n) m_reset();
        else begin
            m_busy = n_busy; m_grant = n_grant; m_last = n_last; m_to = n_to; m_cnt = n_cnt;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        m_reset();
        half();
        adv();
        rst_n = 1;
    endtask

    initial begin
        clr_in();
        m_reset();
        // reset state
        for (int i = 0; i < 2; i++) begin
            half();
            chk("rst_busy", {31'd0, o_busy}, 32'd0);
            chk("rst_grant", {31'd0, o_grant}, 32'd0);
            chk("rst_timeout", {31'd0, o_timeout}, 32'd0);
            chk("rst_mem_addr", o_mem_addr, 32'd0);
            adv();
        end
        rst_n = 1;

        // single read, memory answers 3 cycles after mem_rreq rises
        p0_rreq = 1; p0_addr = 32'h100;
        half(); chk("sr_idle_rreq", {31'd0, o_mem_rreq}, 32'd0); adv();
        half();
        chk("sr_addr", o_mem_addr, 32'h100);
        chk("sr_rreq", {31'd0, o_mem_rreq}, 32'd1);
        chk("sr_grant", {31'd0, o_grant}, 32'd0);
        adv();
        half(); adv();
        half(); adv();
        mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
        half();
        chk("sr_p0_rvalid", {31'd0, o_p0_rvalid}, 32'd1);
        chk("sr_p0_rdata", o_p0_rdata, 32'hDEADBEEF);
        chk("sr_p1_rvalid", {31'd0, o_p1_rvalid}, 32'd0);
        chk("sr_p1_rdata", o_p1_rdata, 32'd0);
        adv();
        clr_in();
        half(); chk("sr_bubble", {31'd0, o_busy}, 32'd0); adv();

        // tie after reset goes to port 0, then port 1 after one IDLE cycle
        do_reset();
        p0_wreq = 1; p1_rreq = 1;
        half(); adv();
        mem_wvalid = 1;
        half();
        chk("tie_grant0", {31'd0, o_grant}, 32'd0);
        chk("tie_p0_wvalid", {31'd0, o_p0_wvalid}, 32'd1);
        adv();
        p0_wreq = 0; mem_wvalid = 0;
        half(); chk("tie_bubble", {31'd0, o_busy}, 32'd0); adv();
        mem_rvalid = 1;
        half();
        chk("tie_busy1", {31'd0, o_busy}, 32'd1);
        chk("tie_grant1", {31'd0, o_grant}, 32'd1);
        chk("tie_p1_rvalid", {31'd0, o_p1_rvalid}, 32'd1);
        adv();
        clr_in();
        half(); adv();

        // round-robin under continuous requests
        p0_rreq = 1; p1_wreq = 1; mem_rvalid = 1; mem_wvalid = 1;
        for (int i = 0; i < 8; i++) begin
            half();
            chk("rr_busy", {31'd0, o_busy}, (i % 2 == 1) ? 32'd1 : 32'd0);
            if (i % 2 == 1) chk("rr_grant", {31'd0, o_grant}, ((i / 2) % 2 == 1) ? 32'd1 : 32'd0);
            adv();
        end
        clr_in();
        half(); adv();

        // write beats read within one port; stray rvalid ignored
        p1_wreq = 1; p1_rreq = 1; p1_be = 4'b0011;
        half(); adv();
        mem_rvalid = 1;
        half();
        chk("wp_wreq", {31'd0, o_mem_wreq}, 32'd1);
        chk("wp_rreq", {31'd0, o_mem_rreq}, 32'd0);
        chk("wp_be", {28'd0, o_mem_be}, 32'h3);
        chk("wp_p1_rvalid", {31'd0, o_p1_rvalid}, 32'd0);
        adv();
        mem_rvalid = 0; mem_wvalid = 1;
        half(); chk("wp_p1_wvalid", {31'd0, o_p1_wvalid}, 32'd1); adv();
        clr_in();
        half(); adv();

        // watchdog then abort
        do_reset();
        p0_rreq = 1;
        half(); adv();
        for (int i = 1; i <= 4; i++) begin
            half();
            if (i == 4) chk("wd_not_yet", {31'd0, o_timeout}, 32'd0);
            adv();
        end
        half();
        chk("wd_timeout", {31'd0, o_timeout}, 32'd1);
        chk("wd_busy", {31'd0, o_busy}, 32'd1);
        adv();
        p0_rreq = 0; mem_rvalid = 1;
        half(); chk("ab_no_rvalid", {31'd0, o_p0_rvalid}, 32'd0); adv();
        mem_rvalid = 0;
        half();
        chk("ab_idle", {31'd0, o_busy}, 32'd0);
        chk("ab_timeout_sticky", {31'd0, o_timeout}, 32'd1);
        adv();

        // asynchronous reset while BUSY
        p0_rreq = 1;
        half(); adv();
        half(); chk("rm_busy", {31'd0, o_busy}, 32'd1); adv();
        rst_n = 0;
        m_reset();
        #1;
        chk("rm_busy0", {31'd0, o_busy}, 32'd0);
        chk("rm_rreq0", {31'd0, o_mem_rreq}, 32'd0);
        chk("rm_addr0", o_mem_addr, 32'd0);
        chk("rm_timeout0", {31'd0, o_timeout}, 32'd0);
        p0_rreq = 0; mem_rvalid = 1;
        half(); adv();
        rst_n = 1;
        half(); chk("rm_late_rvalid", {31'd0, o_p0_rvalid}, 32'd0); adv();
        mem_rvalid = 0; p0_wreq = 1; p1_wreq = 1;
        half(); adv();
        half(); chk("rm_tie_grant", {31'd0, o_grant}, 32'd0); adv();

        // randomized traffic
        h0 = 1; k0 = 2'b01; h1 = 1; k1 = 2'b01;
        for (int c = 0; c < 3000; c++) begin
            if (h0 && (e_done0 || $urandom_range(0, 19) == 0)) h0 = 0;
            else if (!h0 && $urandom_range(0, 2) == 0) begin h0 = 1; k0 = 2'($urandom_range(1, 3)); end
            if (h1 && (e_done1 || $urandom_range(0, 19) == 0)) h1 = 0;
            else if (!h1 && $urandom_range(0, 2) == 0) begin h1 = 1; k1 = 2'($urandom_range(1, 3)); end
            p0_wreq = h0 & k0[0]; p0_rreq = h0 & k0[1];
            p1_wreq = h1 & k1[0]; p1_rreq = h1 & k1[1];
            p0_addr = $urandom; p0_wdata = $urandom; p0_be = 4'($urandom);
            p1_addr = $urandom; p1_wdata = $urandom; p1_be = 4'($urandom);
            mem_wvalid = ($urandom_range(0, 2) == 0);
            mem_rvalid = ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom;
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 0;
                m_reset();
            end
            half();
            adv();
            rst_n = 1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
